// File: rtl/mips_bus_bridge_if.sv
// Bus bundle between mips_core, the data RAM and the peripheral channels.
// The bridge takes the slave view; the core/RAM/peripheral side takes the master view.
interface mips_bus_bridge_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_PERIPH = 4
);
  logic                       mem_ren;
  logic                       mem_wen;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_dout;
  logic [DATA_W-1:0]          mem_din;
  logic                       mem_stall;
  logic                       ram_we;
  logic [ADDR_W-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_din;
  logic [DATA_W-1:0]          ram_dout;
  logic [N_PERIPH-1:0]        per_req;
  logic                       per_we;
  logic [ADDR_W-1:0]          per_addr;
  logic [DATA_W-1:0]          per_wdata;
  logic [N_PERIPH*DATA_W-1:0] per_rdata;
  logic [N_PERIPH-1:0]        per_ack;
  logic                       err_clr;
  logic                       bus_err;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, ram_dout, per_rdata, per_ack, err_clr,
    output mem_din, mem_stall, ram_we, ram_addr, ram_din, per_req, per_we, per_addr,
           per_wdata, bus_err
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, ram_dout, per_rdata, per_ack, err_clr,
    input  mem_din, mem_stall, ram_we, ram_addr, ram_din, per_req, per_we, per_addr,
           per_wdata, bus_err
  );
endinterface

// File: rtl/mips_bus_bridge.sv
// Data-side interconnect: routes core accesses to the data RAM or N_PERIPH req/ack channels.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module mips_bus_bridge #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              N_PERIPH    = 4,
  parameter int              CH_LSB      = 12,
  parameter int              TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  mips_bus_bridge_if.slave  bus
);
  localparam int CH_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;

  typedef enum logic [1:0] {IDLE, RAM_RD, PER_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;

  logic                access, per_space, unmapped, timeout;
  logic [7:0]          ch_field;
  logic [DATA_W-1:0]   ch_rdata [N_PERIPH];

  // E/F top nibble both share the pattern 3'b111 in the top three bits.
  assign access    = bus.mem_ren | bus.mem_wen;
  assign per_space = (bus.mem_addr[ADDR_W-1 -: 3] == 3'b111);
  assign ch_field  = bus.mem_addr[CH_LSB +: 8];
  // Below N_PERIPH implies both a legal index and zero bits above the index field.
  assign unmapped  = (int'(ch_field) >= N_PERIPH);

  genvar gi;
  generate
    for (gi = 0; gi < N_PERIPH; gi++) begin : g_ch
      assign ch_rdata[gi]    = bus.per_rdata[gi*DATA_W +: DATA_W];
      assign bus.per_req[gi] = (state_q == PER_WAIT) && (ch_q == CH_W'(gi));
    end
  endgenerate

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero whenever PER_WAIT is entered, so the limit counts PER_WAIT cycles.
  always_comb begin
    cnt_d = '0;
    if (state_q == PER_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    rdata_d       = rdata_q;
    bus_err_d     = bus_err_q;
    bus.mem_stall = 1'b0;
    bus.ram_we    = 1'b0;
    bus.mem_din   = '0;
    if (bus.err_clr) bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!per_space) begin
            if (bus.mem_wen) begin
              bus.ram_we = 1'b1;
            end else begin
              bus.mem_stall = 1'b1;
              state_d       = RAM_RD;
            end
          end else begin
            bus.mem_stall = 1'b1;
            if (unmapped) begin
              bus_err_d = 1'b1;
              rdata_d   = ERR_DATA;
              state_d   = DONE;
            end else begin
              ch_d    = ch_field[CH_W-1:0];
              addr_d  = bus.mem_addr;
              wdata_d = bus.mem_dout;
              we_d    = bus.mem_wen;
              state_d = PER_WAIT;
            end
          end
        end
      end
      RAM_RD: begin
        bus.mem_din = bus.ram_dout;
        state_d     = IDLE;
      end
      PER_WAIT: begin
        bus.mem_stall = 1'b1;
        if (bus.per_ack[ch_q]) begin
          rdata_d = ch_rdata[ch_q];
          state_d = DONE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          rdata_d   = ERR_DATA;
          state_d   = DONE;
        end
      end
      DONE: begin
        bus.mem_din = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.ram_addr  = {2'b00, bus.mem_addr[ADDR_W-1:2]};
  assign bus.ram_din   = bus.mem_dout;
  assign bus.per_we    = (state_q == PER_WAIT) && we_q;
  assign bus.per_addr  = addr_q;
  assign bus.per_wdata = wdata_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mips_bus_bridge.sv
// Self-checking bench for mips_bus_bridge: directed cases then randomized accesses
// checked against a transaction-level model of RAM contents, latencies and error flag.
module tb_mips_bus_bridge;
  localparam int NP   = 4;
  localparam int TO   = 8;
  localparam int MAXC = 300;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic err_model = 1'b0;
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  logic [31:0] ram_arr [64] = '{default: 32'h0};

  always #5 clk = ~clk;

  mips_bus_bridge_if #(.DATA_W(32), .ADDR_W(32), .N_PERIPH(NP)) bus ();

  mips_bus_bridge #(
    .DATA_W(32), .ADDR_W(32), .N_PERIPH(NP), .CH_LSB(12),
    .TIMEOUT_CYC(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous data RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_we) ram_arr[bus.ram_addr[5:0]] <= bus.ram_din;
    bus.ram_dout <= ram_arr[bus.ram_addr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core access; ack_k = PER_WAIT cycle of the ack (0 = never ack).
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int ack_k, input logic [31:0] prdata,
                     input logic clr);
    int          ch, idx, stalls, req_cycles, ram_we_cycles, exp_stall, exp_req;
    logic        periph, unm, mapped, done, bad, exp_set;
    logic [31:0] din, exp_din;
    logic [NP-1:0] oh;
    ch     = int'((addr >> 12) & 32'hFF);
    idx    = int'((addr >> 2) & 32'h3F);
    periph = (addr >= 32'hE000_0000);
    unm    = periph && (ch >= NP);
    mapped = periph && !unm;
    oh     = mapped ? NP'(1) << ch : '0;
    exp_set = 1'b0;
    exp_req = 0;
    exp_din = 32'h0;
    if (!periph) begin
      exp_stall = wr ? 0 : 1;
      exp_din   = ref_mem[idx];
    end else if (unm) begin
      exp_stall = 1;
      exp_din   = ERRD;
      exp_set   = 1'b1;
    end else if (ack_k > 0) begin
      exp_stall = 1 + ack_k;
      exp_req   = ack_k;
      exp_din   = prdata;
    end else begin
      exp_stall = 1 + TO;
      exp_req   = TO;
      exp_din   = ERRD;
      exp_set   = 1'b1;
    end

    bus.mem_wen  = wr;
    bus.mem_ren  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.mem_addr = addr;
    bus.mem_dout = wdata;
    bus.err_clr  = clr;
    stalls = 0; req_cycles = 0; ram_we_cycles = 0; done = 1'b0; bad = 1'b0; din = 32'h0;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      bus.per_ack   = NP'($urandom) & ~oh;
      bus.per_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (cyc > 0) bus.err_clr = 1'b0;
      #1;
      if (bus.ram_we) begin
        ram_we_cycles++;
        if (bus.ram_din !== wdata || bus.ram_addr !== {2'b00, addr[31:2]}) bad = 1'b1;
      end
      if (bus.per_req !== '0) begin
        req_cycles++;
        if (bus.per_req !== oh || bus.per_addr !== addr || bus.per_we !== wr ||
            bus.per_wdata !== wdata) bad = 1'b1;
        if (req_cycles == ack_k) begin
          bus.per_ack[ch] = 1'b1;
          bus.per_rdata[ch*32 +: 32] = prdata;
        end
      end else if (bus.per_we !== 1'b0) begin
        bad = 1'b1;
      end
      if (bus.mem_stall === 1'b0) begin
        done = 1'b1;
        din  = bus.mem_din;
      end else begin
        stalls++;
      end
      @(negedge clk);
      if (done) break;
    end
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;
    bus.per_ack = '0;
    bus.err_clr = 1'b0;

    if (clr) err_model = 1'b0;
    if (exp_set) err_model = 1'b1;
    if (!periph && wr) ref_mem[idx] = wdata;

    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall"}, stalls, exp_stall);
    if (!wr) check({tag, "_din"}, din, exp_din);
    check({tag, "_ramwe"}, ram_we_cycles, (!periph && wr) ? 1 : 0);
    if (mapped) check({tag, "_req"}, req_cycles, exp_req);
    check({tag, "_hold"}, 32'(bad), 32'd0);
    #1;
    check({tag, "_err"}, 32'(bus.bus_err), 32'(err_model));
    $display("[TB] %s %s addr=%h stall=%0d din=%h err=%b", tag, wr ? "W" : "R", addr, stalls,
             din, bus.bus_err);
    @(negedge clk);
  endtask

  initial begin
    int          kind, ch, idx;
    logic [31:0] addr;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_dout  = '0;
    bus.per_rdata = '0;
    bus.per_ack   = '0;
    bus.err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(bus.mem_stall), 32'd0);
    check("rst_req", 32'(bus.per_req), 32'd0);
    check("rst_per_we", 32'(bus.per_we), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_din", bus.mem_din, 32'd0);
    @(negedge clk);

    txn("ram_wr", 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0, 1'b0);
    txn("ram_rd", 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b0);
    txn("per_rd_ch1", 1'b0, 32'hE000_1000, 32'h0, 3, 32'hCAFE_0001, 1'b0);
    txn("per_wr_ch3", 1'b1, 32'hF000_3004, 32'hA5A5_A5A5, 1, 32'h0, 1'b0);
    txn("unmapped", 1'b0, 32'hE000_8000, 32'h0, 0, 32'h0, 1'b0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    err_model   = 1'b0;
    #1;
    check("err_clr", 32'(bus.bus_err), 32'd0);
    @(negedge clk);
    txn("unm_set_wins", 1'b1, 32'hF001_0000, 32'h5, 0, 32'h0, 1'b1);
    txn("clr_only", 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b1);
`ifdef BUS_TIMEOUT_EN
    txn("timeout_ch2", 1'b0, 32'hE000_2000, 32'h0, 0, 32'h0, 1'b0);
`endif

    // Reset in the middle of a peripheral wait; the late ack must be ignored.
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 32'hE000_2000;
    bus.per_ack  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid_req_before", 32'(bus.per_req), 32'h4);
    rst = 1'b1;
    bus.mem_ren = 1'b0;
    @(negedge clk);
    #1;
    err_model = 1'b0;
    check("rst_mid_req", 32'(bus.per_req), 32'd0);
    check("rst_mid_stall", 32'(bus.mem_stall), 32'd0);
    rst = 1'b0;
    bus.per_ack = NP'(4);
    bus.per_rdata[2*32 +: 32] = 32'h7777_7777;
    @(negedge clk);
    #1;
    check("late_ack_req", 32'(bus.per_req), 32'd0);
    check("late_ack_stall", 32'(bus.mem_stall), 32'd0);
    check("late_ack_din", bus.mem_din, 32'd0);
    bus.per_ack = '0;
    @(negedge clk);
    #1;
    check("late_ack_din2", bus.mem_din, 32'd0);
    check("late_ack_err", 32'(bus.bus_err), 32'd0);
    @(negedge clk);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 4);
      ch   = $urandom_range(0, NP - 1);
      idx  = $urandom_range(0, 63);
      case (kind)
        0, 1: addr = (32'($urandom_range(0, 13)) << 28) | ($urandom & 32'h0FFF_FF00) |
                     32'(idx << 2);
        2, 3: addr = (32'($urandom_range(14, 15)) << 28) | ($urandom & 32'h0FF0_0FFC) |
                     32'(ch << 12);
        default: addr = (32'($urandom_range(14, 15)) << 28) | ($urandom & 32'h0FF0_0FFC) |
                        (32'($urandom_range(NP, 255)) << 12);
      endcase
      txn("rand", (kind == 0 || kind == 2) ? 1'b1 : 1'($urandom_range(0, 1) & (kind == 4)),
          addr, $urandom, $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
